fetch_stage: RTL and testbench

Instruction-fetch stage for the pipelined-plus-cache core, directly upstream of decode. Owns the fetch PC and drives the instruction cache with a request/grant/response handshake. Buffers returned instructions in a 2-entry queue and presents them to decode through a registered fetch/decode boundary with valid, stall and redirect handling. Its outputs feed the decode logic whose results are captured by the decode/execute register.

---
 rtl/fetch_stage_if.sv | 32 +++
 rtl/fetch_stage.sv | 180 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Instruction-cache fetch handshake bundle.
//   ic_req    fetch -> cache   request valid
//   ic_addr   fetch -> cache   word-aligned fetch address
//   ic_gnt    cache -> fetch   request accepted when ic_req && ic_gnt
//   ic_rvalid cache -> fetch   in-order response valid
//   ic_rdata  cache -> fetch   instruction word for the outstanding request
// master: fetch stage side, slave: cache side.
interface fetch_stage_if #(
   parameter int DATA_WIDTH = 32
);
   logic                  ic_req;
   logic [DATA_WIDTH-1:0] ic_addr;
   logic                  ic_gnt;
   logic                  ic_rvalid;
   logic [DATA_WIDTH-1:0] ic_rdata;

   modport master (
      output ic_req,
      output ic_addr,
      input  ic_gnt,
      input  ic_rvalid,
      input  ic_rdata
   );

   modport slave (
      input  ic_req,
      input  ic_addr,
      output ic_gnt,
      output ic_rvalid,
      output ic_rdata
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage. Owns the fetch PC, keeps at most one request in
// flight to the instruction cache, buffers responses in a 2-entry queue and
// drives a registered fetch/decode boundary with stall (en) and redirect.
//   clk, rst     clock, synchronous active-high reset
//   ic           cache handshake (master side)
//   redirect     flush and refetch from redirect_pc
//   en           advance the decode boundary; low holds outputs
//   valid_d      instr_d/PC_d/PCPlus4_d hold a live instruction
//   instr_d, PC_d, PCPlus4_d   instruction to decode, its PC and PC+4
module fetch_stage #(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   fetch_stage_if.master         ic,
   input  logic                  redirect,
   input  logic [DATA_WIDTH-1:0] redirect_pc,
   input  logic                  en,
   output logic                  valid_d,
   output logic [DATA_WIDTH-1:0] instr_d,
   output logic [DATA_WIDTH-1:0] PC_d,
   output logic [DATA_WIDTH-1:0] PCPlus4_d
);

   localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

   logic [DATA_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [DATA_WIDTH-1:0] req_pc_q, req_pc_d;
   logic                  outst_q, outst_d;
   logic                  kill_q, kill_d;
   logic [DATA_WIDTH-1:0] fifo_pc_q    [2];
   logic [DATA_WIDTH-1:0] fifo_pc_d    [2];
   logic [DATA_WIDTH-1:0] fifo_instr_q [2];
   logic [DATA_WIDTH-1:0] fifo_instr_d [2];
   logic [1:0]            count_q, count_d;
   logic                  valid_q, valid_nx;
   logic [DATA_WIDTH-1:0] instr_q, instr_nx;
   logic [DATA_WIDTH-1:0] pc_q, pc_nx;
   logic [DATA_WIDTH-1:0] pc4_q, pc4_nx;

   logic       resp;
   logic       deliver;
   logic       pop;
   logic       push;
   logic       wr_idx;
   logic [2:0] count_nx;
   logic       req;
   logic       gnt;

   // A response is only honoured while a request is outstanding; a killed
   // response, or one landing in a redirect cycle, is consumed but dropped.
   assign resp    = ic.ic_rvalid && outst_q;
   assign deliver = resp && !kill_q && !redirect;
   assign pop     = en && !redirect && (count_q != 2'd0);
   // With en high and an empty queue the response bypasses into the outputs.
   assign push    = deliver && !(en && (count_q == 2'd0));
   assign wr_idx  = pop ? (count_q == 2'd2) : (count_q == 2'd1);

   assign count_nx = {1'b0, count_q} + {2'b00, push} - {2'b00, pop};

   // Only issue when the response to this request is guaranteed a slot.
   // Independent of ic_gnt so the cache may derive its grant from ic_req.
   assign req = !rst && !redirect && (!outst_q || ic.ic_rvalid) &&
                (count_nx <= 3'd1);
   assign gnt = req && ic.ic_gnt;

   assign ic.ic_req  = req;
   assign ic.ic_addr = fetch_pc_q;

   assign valid_d   = valid_q;
   assign instr_d   = instr_q;
   assign PC_d      = pc_q;
   assign PCPlus4_d = pc4_q;

   always_comb begin
      fetch_pc_d   = fetch_pc_q;
      req_pc_d     = req_pc_q;
      outst_d      = outst_q;
      kill_d       = kill_q;
      fifo_pc_d    = fifo_pc_q;
      fifo_instr_d = fifo_instr_q;
      count_d      = count_q;
      valid_nx     = valid_q;
      instr_nx     = instr_q;
      pc_nx        = pc_q;
      pc4_nx       = pc4_q;

      if (redirect) begin
         fetch_pc_d = redirect_pc;
      end else if (gnt) begin
         fetch_pc_d = fetch_pc_q + PC_STEP;
      end

      if (gnt) begin
         req_pc_d = fetch_pc_q;
         outst_d  = 1'b1;
      end else if (resp) begin
         outst_d  = 1'b0;
      end

      if (resp && kill_q) begin
         kill_d = 1'b0;
      end
      // A request still in flight after a redirect belongs to the old path.
      if (redirect) begin
         kill_d = outst_d;
      end

      if (redirect) begin
         count_d = 2'd0;
      end else begin
         if (pop) begin
            fifo_pc_d[0]    = fifo_pc_q[1];
            fifo_instr_d[0] = fifo_instr_q[1];
         end
         if (push) begin
            fifo_pc_d[wr_idx]    = req_pc_q;
            fifo_instr_d[wr_idx] = ic.ic_rdata;
         end
         count_d = count_nx[1:0];
      end

      if (redirect) begin
         valid_nx = 1'b0;
      end else if (en) begin
         if (count_q != 2'd0) begin
            valid_nx = 1'b1;
            instr_nx = fifo_instr_q[0];
            pc_nx    = fifo_pc_q[0];
            pc4_nx   = fifo_pc_q[0] + PC_STEP;
         end else if (deliver) begin
            valid_nx = 1'b1;
            instr_nx = ic.ic_rdata;
            pc_nx    = req_pc_q;
            pc4_nx   = req_pc_q + PC_STEP;
         end else begin
            valid_nx = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q   <= RESET_PC;
         req_pc_q     <= RESET_PC;
         outst_q      <= 1'b0;
         kill_q       <= 1'b0;
         fifo_pc_q    <= '{default: '0};
         fifo_instr_q <= '{default: '0};
         count_q      <= 2'd0;
         valid_q      <= 1'b0;
         instr_q      <= '0;
         pc_q         <= '0;
         pc4_q        <= '0;
      end else begin
         fetch_pc_q   <= fetch_pc_d;
         req_pc_q     <= req_pc_d;
         outst_q      <= outst_d;
         kill_q       <= kill_d;
         fifo_pc_q    <= fifo_pc_d;
         fifo_instr_q <= fifo_instr_d;
         count_q      <= count_d;
         valid_q      <= valid_nx;
         instr_q      <= instr_nx;
         pc_q         <= pc_nx;
         pc4_q        <= pc4_nx;
      end
   end

   // The issue rule reserves a slot for every in-flight response, so the
   // queue can never be asked to hold a third entry.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (count_nx <= 3'd2)
            else $error("fetch_stage: instruction queue overflow");
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
   localparam logic [31:0] TAG = 32'hC000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        en;
   logic        valid_d;
   logic [31:0] instr_d;
   logic [31:0] PC_d;
   logic [31:0] PCPlus4_d;

   always #5 clk = ~clk;

   fetch_stage_if #(.DATA_WIDTH(32)) ic ();

   fetch_stage #(.DATA_WIDTH(32), .RESET_PC(32'h0)) dut (
      .clk         (clk),
      .rst         (rst),
      .ic          (ic),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .en          (en),
      .valid_d     (valid_d),
      .instr_d     (instr_d),
      .PC_d        (PC_d),
      .PCPlus4_d   (PCPlus4_d)
   );

   int          errors = 0;
   int          checks = 0;
   int          lat;
   int          cnt;
   logic        pend;
   logic [31:0] pend_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic [31:0] pc);
      chkb({tag, "_valid"}, valid_d, 1'b1);
      chk({tag, "_pc"}, PC_d, pc);
      chk({tag, "_instr"}, instr_d, pc ^ TAG);
      chk({tag, "_pc4"}, PCPlus4_d, pc + 32'd4);
   endtask

   // One clock: sample the request just before the edge, then advance the
   // cache model (fixed latency, data = addr ^ TAG) and drive its response.
   task automatic cycle();
      logic        fire;
      logic [31:0] a;
      #1;
      fire = ic.ic_req && ic.ic_gnt;
      a    = ic.ic_addr;
      @(posedge clk);
      #1;
      if (ic.ic_rvalid) pend = 1'b0;
      if (fire) begin
         pend      = 1'b1;
         pend_addr = a;
         cnt       = lat;
      end else if (pend) begin
         cnt--;
      end
      ic.ic_rvalid = pend && (cnt == 1);
      ic.ic_rdata  = (pend && (cnt == 1)) ? (pend_addr ^ TAG) : 32'hDEAD_BEEF;
      #1;
   endtask

   task automatic do_reset();
      rst          = 1'b1;
      pend         = 1'b0;
      ic.ic_rvalid = 1'b0;
      cycle();
      cycle();
      rst = 1'b0;
      #1;
   endtask

   initial begin
      rst          = 1'b1;
      en           = 1'b1;
      redirect     = 1'b0;
      redirect_pc  = 32'h0;
      ic.ic_gnt    = 1'b1;
      ic.ic_rvalid = 1'b0;
      ic.ic_rdata  = 32'h0;
      lat          = 1;
      pend         = 1'b0;
      cnt          = 0;
      pend_addr    = 32'h0;

      // reset state
      cycle();
      cycle();
      chkb("rst_req", ic.ic_req, 1'b0);
      chk("rst_addr", ic.ic_addr, 32'h0);
      chkb("rst_valid", valid_d, 1'b0);
      chk("rst_instr", instr_d, 32'h0);
      chk("rst_pc", PC_d, 32'h0);
      chk("rst_pc4", PCPlus4_d, 32'h0);
      rst = 1'b0;
      #1;

      // 1-cycle hit cache, grant always high
      for (int c = 0; c < 5; c++) begin
         chkb("t1_req", ic.ic_req, 1'b1);
         if (c < 3) chk("t1_addr", ic.ic_addr, 32'(4 * c));
         if (c >= 2) chk_out("t1", 32'(4 * (c - 2)));
         else chkb("t1_bubble", valid_d, 1'b0);
         if (c < 4) cycle();
      end

      // en low for 4 cycles: hold outputs, queue fills, request drops
      en = 1'b0;
      #1;
      chkb("t2_req_c4", ic.ic_req, 1'b1);
      cycle();
      chk_out("t2_hold5", 32'h8);
      chkb("t2_req_c5", ic.ic_req, 1'b0);
      cycle();
      chk_out("t2_hold6", 32'h8);
      chkb("t2_req_c6", ic.ic_req, 1'b0);
      cycle();
      chk_out("t2_hold7", 32'h8);
      chkb("t2_req_c7", ic.ic_req, 1'b0);
      cycle();
      chk_out("t2_hold8", 32'h8);
      en = 1'b1;
      #1;
      chkb("t2_req_c8", ic.ic_req, 1'b1);
      chk("t2_addr_c8", ic.ic_addr, 32'h14);
      for (int k = 0; k < 4; k++) begin
         cycle();
         chk_out("t2_resume", 32'(12 + 4 * k));
      end

      // 5-cycle response latency
      lat = 5;
      do_reset();
      for (int c = 0; c < 17; c++) begin
         chkb("t3_req", ic.ic_req, (c % 5) == 0);
         if (c == 6 || c == 11 || c == 16) chk_out("t3", 32'(4 * ((c - 6) / 5)));
         else chkb("t3_bubble", valid_d, 1'b0);
         if (c < 16) cycle();
      end

      // redirect to 0x100 while the request to 0x40 is outstanding
      lat = 3;
      do_reset();
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      #1;
      chkb("t4_req_forced", ic.ic_req, 1'b0);
      cycle();
      redirect = 1'b0;
      #1;
      chkb("t4_req_c1", ic.ic_req, 1'b1);
      chk("t4_addr_c1", ic.ic_addr, 32'h40);
      chkb("t4_valid_c1", valid_d, 1'b0);
      cycle();
      redirect    = 1'b1;
      redirect_pc = 32'h100;
      #1;
      chkb("t4_req_c2", ic.ic_req, 1'b0);
      cycle();
      redirect = 1'b0;
      #1;
      chkb("t4_req_c3", ic.ic_req, 1'b0);
      chk("t4_addr_c3", ic.ic_addr, 32'h100);
      cycle();
      chkb("t4_req_c4", ic.ic_req, 1'b1);
      chk("t4_addr_c4", ic.ic_addr, 32'h100);
      for (int c = 5; c < 8; c++) begin
         cycle();
         chkb("t4_drop", valid_d, 1'b0);
      end
      cycle();
      chk_out("t4_first", 32'h100);

      // redirect coinciding with a response while en is low
      lat = 1;
      do_reset();
      cycle();
      cycle();
      chk_out("t5_pre", 32'h0);
      en          = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'h200;
      #1;
      chkb("t5_req_forced", ic.ic_req, 1'b0);
      cycle();
      redirect = 1'b0;
      en       = 1'b1;
      #1;
      chkb("t5_valid_c3", valid_d, 1'b0);
      chkb("t5_req_c3", ic.ic_req, 1'b1);
      chk("t5_addr_c3", ic.ic_addr, 32'h200);
      cycle();
      chkb("t5_fifo_empty", valid_d, 1'b0);
      cycle();
      chk_out("t5_first", 32'h200);

      // 1-cycle reset pulse with a response still pending
      lat = 3;
      do_reset();
      for (int c = 0; c < 4; c++) cycle();
      chk_out("t6_pre", 32'h0);
      cycle();
      rst       = 1'b1;
      ic.ic_gnt = 1'b0;
      #1;
      chkb("t6_req_rst", ic.ic_req, 1'b0);
      cycle();
      chkb("t6_valid", valid_d, 1'b0);
      chk("t6_instr", instr_d, 32'h0);
      chk("t6_pc", PC_d, 32'h0);
      chk("t6_pc4", PCPlus4_d, 32'h0);
      chk("t6_addr", ic.ic_addr, 32'h0);
      rst = 1'b0;
      #1;
      chkb("t6_req_restart", ic.ic_req, 1'b1);
      cycle();
      chkb("t6_stale_ignored", valid_d, 1'b0);
      ic.ic_gnt = 1'b1;
      #1;
      chkb("t6_req_c7", ic.ic_req, 1'b1);
      chk("t6_addr_c7", ic.ic_addr, 32'h0);
      for (int c = 0; c < 4; c++) cycle();
      chk_out("t6_first", 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
